avalon_pio_ctrl: RTL



---
 rtl/avalon_pio_pkg.sv | 22 ++
 rtl/pio_sync_edge.sv | 49 ++++
 rtl/avalon_pio_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM PIO controller: register map, edge
// selection encodings and the bus data width limit.
package avalon_pio_pkg;

  localparam int PIO_MAX_WIDTH = 32;

  typedef enum logic [2:0] {
    ADDR_DATA     = 3'd0,
    ADDR_DIR      = 3'd1,
    ADDR_IRQ_MASK = 3'd2,
    ADDR_EDGE_CAP = 3'd3,
    ADDR_OUTSET   = 3'd4,
    ADDR_OUTCLR   = 3'd5,
    ADDR_OUTTGL   = 3'd6,
    ADDR_RSVD     = 3'd7
  } pio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain plus one-cycle history register; emits the
// synchronised pins and a per-bit edge pulse of the selected polarity.
module pio_sync_edge
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STAGES    = 2,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  // Flushing the whole chain to 0 means a pin held high across reset is
  // later seen as a genuine rising edge, never as a falling one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_o = ~sync_o & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_o = sync_o ^ prev_q;
    end else begin : g_rise
      assign edge_o = sync_o & ~prev_q;
    end
  endgenerate

endmodule

// File: rtl/avalon_pio_ctrl.sv
// Avalon-MM GPIO slave: output register, direction, edge capture and masked irq.
// Define AVALON_PIO_BIT_OPS_EN to add atomic OUTSET/OUTCLR/OUTTGL at addresses 4-6.
module avalon_pio_ctrl
  import avalon_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_DIR   = '0,
  parameter int                    EDGE_TYPE   = EDGE_RISE,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2:0]               address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [PIO_MAX_WIDTH-1:0] writedata,
  output logic [PIO_MAX_WIDTH-1:0] readdata,
  input  logic [DATA_WIDTH-1:0]    in_port,
  output logic [DATA_WIDTH-1:0]    out_port,
  output logic [DATA_WIDTH-1:0]    oe,
  output logic                     irq
);

  pio_addr_e             addr;
  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] sync_in;
  logic [DATA_WIDTH-1:0] edge_pulse;
  logic [DATA_WIDTH-1:0] rd_val;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic                  irq_q, irq_d;

  assign addr = pio_addr_e'(address);
  assign wr   = chipselect & ~write_n;
  assign wd   = writedata[DATA_WIDTH-1:0];

  generate
    if (DATA_WIDTH < PIO_MAX_WIDTH) begin : g_wd_hi
      logic unused_wd_hi;
      assign unused_wd_hi = ^writedata[PIO_MAX_WIDTH-1:DATA_WIDTH];
    end
  endgenerate

  pio_sync_edge #(
    .WIDTH     (DATA_WIDTH),
    .STAGES    (SYNC_STAGES),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (in_port),
    .sync_o  (sync_in),
    .edge_o  (edge_pulse)
  );

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr) begin
      case (addr)
        ADDR_DATA:     data_d = wd;
        ADDR_DIR:      dir_d  = wd;
        ADDR_IRQ_MASK: mask_d = wd;
        ADDR_EDGE_CAP: cap_d  = cap_q & ~wd;
`ifdef AVALON_PIO_BIT_OPS_EN
        ADDR_OUTSET:   data_d = data_q | wd;
        ADDR_OUTCLR:   data_d = data_q & ~wd;
        ADDR_OUTTGL:   data_d = data_q ^ wd;
`endif
        default:       data_d = data_q;
      endcase
    end
    // A fresh edge overrides a same-cycle W1C so no event is lost.
    cap_d = cap_d | edge_pulse;
  end

  assign irq_d = |(cap_q & mask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      dir_q  <= RESET_DIR;
      mask_q <= '0;
      cap_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_DATA:     rd_val = (data_q & dir_q) | (sync_in & ~dir_q);
      ADDR_DIR:      rd_val = dir_q;
      ADDR_IRQ_MASK: rd_val = mask_q;
      ADDR_EDGE_CAP: rd_val = cap_q;
      default:       rd_val = '0;
    endcase
    readdata = '0;
    readdata[DATA_WIDTH-1:0] = rd_val;
  end

  assign out_port = data_q;
  assign oe       = dir_q;
  assign irq      = irq_q;

endmodule
